aes_inv_sub_bytes: RTL and testbench

Applies the AES InvSubBytes transform to a full 128-bit state for the decryption datapath. It is the inverse of the forward S-box lookup used in encryption. The 16 state bytes are processed over several beats through LANES registered inverse S-box instances. The block sits between InvShiftRows and AddRoundKey in the decrypt round, using a valid/ready handshake on both sides.

---
 rtl/aes_pkg.sv | 22 ++
 rtl/aes_inv_sub_bytes_if.sv | 22 ++
 rtl/aes_inv_s_box.sv | 42 ++++
 rtl/aes_inv_sub_bytes.sv | 104 ++++++++++
 tb/tb_aes_inv_sub_bytes.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants, byte type and MSB-first byte addressing for a 128-bit state.
package aes_pkg;

  localparam int AES_BLOCK_BITS = 128;
  localparam int AES_BYTES      = 16;

  typedef logic [7:0]                aes_byte_t;
  typedef logic [AES_BLOCK_BITS-1:0] aes_state_t;

  // Byte 0 sits in the top 8 bits of the state (FIPS-197 ordering).
  function automatic aes_byte_t aes_byte_at(aes_state_t s, int idx);
    return s[AES_BLOCK_BITS-1-8*idx -: 8];
  endfunction

  function automatic aes_state_t aes_byte_put(aes_state_t s, int idx, aes_byte_t b);
    aes_state_t r;
    r = s;
    r[AES_BLOCK_BITS-1-8*idx -: 8] = b;
    return r;
  endfunction

endpackage

// File: rtl/aes_inv_sub_bytes_if.sv
// Valid/ready state-in / state-out bundle for the InvSubBytes stage.
interface aes_inv_sub_bytes_if;

  logic               in_valid;
  logic               in_ready;
  aes_pkg::aes_state_t in_state;
  logic               out_valid;
  logic               out_ready;
  aes_pkg::aes_state_t out_state;
  logic               busy;

  modport master (
    output in_valid, in_state, out_ready,
    input  in_ready, out_valid, out_state, busy
  );

  modport slave (
    input  in_valid, in_state, out_ready,
    output in_ready, out_valid, out_state, busy
  );

endinterface

// File: rtl/aes_inv_s_box.sv
// Registered FIPS-197 inverse S-box: one byte per cycle, one cycle of latency.
module aes_inv_s_box
  import aes_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  aes_byte_t in_byte,
  output aes_byte_t out_byte
);

  // Upper nibble selects a table row, lower nibble selects the byte within it.
  function automatic aes_byte_t inv_lookup(aes_byte_t b);
    logic [127:0] row;
    case (b[7:4])
      4'h0: row = 128'h52096ad53036a538bf40a39e81f3d7fb;
      4'h1: row = 128'h7ce339829b2fff87348e4344c4dee9cb;
      4'h2: row = 128'h547b9432a6c2233dee4c950b42fac34e;
      4'h3: row = 128'h082ea16628d924b2765ba2496d8bd125;
      4'h4: row = 128'h72f8f66486689816d4a45ccc5d65b692;
      4'h5: row = 128'h6c704850fdedb9da5e154657a78d9d84;
      4'h6: row = 128'h90d8ab008cbcd30af7e45805b8b34506;
      4'h7: row = 128'hd02c1e8fca3f0f02c1afbd0301138a6b;
      4'h8: row = 128'h3a9111414f67dcea97f2cfcef0b4e673;
      4'h9: row = 128'h96ac7422e7ad3585e2f937e81c75df6e;
      4'ha: row = 128'h47f11a711d29c5896fb7620eaa18be1b;
      4'hb: row = 128'hfc563e4bc6d279209adbc0fe78cd5af4;
      4'hc: row = 128'h1fdda8338807c731b11210592780ec5f;
      4'hd: row = 128'h60517fa919b54a0d2de57a9f93c99cef;
      4'he: row = 128'ha0e03b4dae2af5b0c8ebbb3c83539961;
      4'hf: row = 128'h172b047eba77d626e169146355210c7d;
      default: row = '0;
    endcase
    return row[127-8*int'(b[3:0]) -: 8];
  endfunction

  // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) out_byte <= '0;
    else     out_byte <= inv_lookup(in_byte);
  end

endmodule

// File: rtl/aes_inv_sub_bytes.sv
// InvSubBytes over a 128-bit state, LANES bytes per beat through registered inverse S-boxes.
module aes_inv_sub_bytes
  import aes_pkg::*;
#(
  parameter int LANES = 4
) (
  input logic               clk,
  input logic               rst,
  aes_inv_sub_bytes_if.slave bus
);

  localparam int BEATS = AES_BYTES / LANES;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FEED  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("aes_inv_sub_bytes: LANES must be 1, 2, 4, 8 or 16");
  end

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] beat_q, beat_d;
  aes_state_t       cap_q, cap_d;
  aes_state_t       res_q, res_d;
  aes_byte_t        lane_in  [LANES];
  aes_byte_t        lane_out [LANES];
  logic             wr_en;
  int               wr_beat;

  // Lane j of beat k works on captured byte k*LANES+j.
  always_comb begin
    for (int j = 0; j < LANES; j++) begin
      lane_in[j] = aes_byte_at(cap_q, int'(beat_q) * LANES + j);
    end
  end

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    aes_inv_s_box u_s_box (
      .clk      (clk),
      .rst      (rst),
      .in_byte  (lane_in[j]),
      .out_byte (lane_out[j])
    );
  end

  // S-box outputs lag one beat, so FEED beat k stores beat k-1 and DRAIN stores the last beat.
  always_comb begin
    wr_en   = (state_q == FEED && beat_q != '0) || state_q == DRAIN;
    wr_beat = (state_q == DRAIN) ? BEATS - 1 : int'(beat_q) - 1;
  end

  // NOTE: every variable gets a default at the top of the block, so no path infers a latch.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    cap_d   = cap_q;
    res_d   = res_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          cap_d   = bus.in_state;
          beat_d  = '0;
          state_d = FEED;
        end
      end
      FEED: begin
        if (beat_q == LAST_BEAT) state_d = DRAIN;
        else                     beat_d  = beat_q + 1'b1;
      end
      DRAIN:   state_d = HOLD;
      HOLD:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (wr_en) begin
      for (int j = 0; j < LANES; j++) begin
        res_d = aes_byte_put(res_d, wr_beat * LANES + j, lane_out[j]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      cap_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      cap_q   <= cap_d;
      res_q   <= res_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == HOLD);
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_state = res_q;

endmodule

// File: tb/tb_aes_inv_sub_bytes.sv
// Directed, table-driven bench for aes_inv_sub_bytes (LANES=4 main DUT, LANES=1/16 sweep DUTs).
module tb_aes_inv_sub_bytes;
  import aes_pkg::*;

  typedef struct {
    aes_state_t din;
    aes_state_t dout;
  } vec_t;

  localparam int NVEC  = 19;
  localparam int BOUND = 60;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  aes_inv_sub_bytes_if bus4 ();
  aes_inv_sub_bytes_if bus1 ();
  aes_inv_sub_bytes_if bus16 ();

  aes_inv_sub_bytes #(.LANES(4))  u_dut4  (.clk(clk), .rst(rst), .bus(bus4));
  aes_inv_sub_bytes #(.LANES(1))  u_dut1  (.clk(clk), .rst(rst), .bus(bus1));
  aes_inv_sub_bytes #(.LANES(16)) u_dut16 (.clk(clk), .rst(rst), .bus(bus16));

  // Forward FIPS-197 S-box, used to build exhaustive vectors and the round-trip check.
  logic [2047:0] fwd_flat = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic aes_byte_t fwd(int v);
    return fwd_flat[2047-8*v -: 8];
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One block through the LANES=4 DUT with out_ready high; lat counts edges after accept.
  task automatic run_block(input aes_state_t din, output aes_state_t dout, output int lat);
    @(negedge clk);
    check("accept_ready", bus4.in_ready, 1'b1);
    bus4.in_valid  = 1'b1;
    bus4.in_state  = din;
    bus4.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus4.in_valid = 1'b0;
    lat  = -1;
    dout = 'x;
    for (int k = 1; k <= BOUND; k++) begin
      @(posedge clk);
      #1;
      if (bus4.out_valid) begin
        lat  = k;
        dout = bus4.out_state;
        break;
      end
    end
    @(posedge clk);
    #1;
    check("valid_one_cycle", bus4.out_valid, 1'b0);
  endtask

  vec_t       vecs [NVEC];
  aes_state_t got, o1, o2, o16;
  int         lat, t1, t2, lat1, lat16, bad;

  initial begin
    bus4.in_valid = 1'b0;  bus4.in_state = '0;  bus4.out_ready = 1'b0;
    bus1.in_valid = 1'b0;  bus1.in_state = '0;  bus1.out_ready = 1'b1;
    bus16.in_valid = 1'b0; bus16.in_state = '0; bus16.out_ready = 1'b1;

    vecs[0] = '{128'h637c777bf26b6fc53001672bfed7ab76, 128'h000102030405060708090a0b0c0d0e0f};
    vecs[1] = '{128'h00637c09521600000000000000000000, 128'h5200014048ff52525252525252525252};
    vecs[2] = '{{16{8'h63}}, 128'h0};
    for (int b = 0; b < 16; b++) begin
      for (int j = 0; j < 16; j++) begin
        vecs[3+b].din[127-8*j -: 8]  = fwd(16*b + j);
        vecs[3+b].dout[127-8*j -: 8] = 8'(16*b + j);
      end
    end

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", bus4.in_ready, 1'b1);
    check("rst_out_valid", bus4.out_valid, 1'b0);
    check("rst_busy", bus4.busy, 1'b0);
    check("rst_out_state", bus4.out_state, 128'h0);
    @(negedge clk);
    rst = 1'b0;

    // Table: basic vector, S-box reference points, all-0x63, then all 256 byte values
    for (int i = 0; i < NVEC; i++) begin
      run_block(vecs[i].din, got, lat);
      check($sformatf("vec%0d_out", i), got, vecs[i].dout);
      check($sformatf("vec%0d_latency", i), lat, 5);
      if (i >= 3) begin
        bad = 0;
        for (int j = 0; j < 16; j++) begin
          if (fwd(int'(aes_byte_at(got, j))) !== aes_byte_at(vecs[i].din, j)) bad++;
        end
        check($sformatf("vec%0d_roundtrip", i), bad, 0);
      end
    end

    // Backpressure: result held, new input ignored while out_ready is low
    @(negedge clk);
    bus4.in_valid  = 1'b1;
    bus4.in_state  = vecs[0].din;
    bus4.out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus4.in_state = {16{8'h63}};
    lat = -1;
    for (int k = 1; k <= BOUND; k++) begin
      @(posedge clk);
      #1;
      if (bus4.out_valid) begin
        lat = k;
        break;
      end
    end
    check("bp_latency", lat, 5);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (!(bus4.out_valid === 1'b1 && bus4.out_state === vecs[0].dout &&
            bus4.in_ready === 1'b0 && bus4.busy === 1'b1)) bad++;
    end
    check("bp_hold_stable", bad, 0);
    @(negedge clk);
    bus4.out_ready = 1'b1;
    bus4.in_valid  = 1'b0;
    @(posedge clk);
    #1;
    check("bp_release_valid", bus4.out_valid, 1'b0);
    check("bp_release_ready", bus4.in_ready, 1'b1);
    check("bp_release_out", bus4.out_state, vecs[0].dout);

    // Back-to-back with in_valid held high
    @(negedge clk);
    bus4.in_valid = 1'b1;
    bus4.in_state = {16{8'h63}};
    @(posedge clk);
    @(negedge clk);
    bus4.in_state = '0;
    t1 = -1;
    t2 = -1;
    o1 = 'x;
    o2 = 'x;
    for (int k = 1; k <= BOUND; k++) begin
      @(posedge clk);
      #1;
      if (bus4.out_valid) begin
        if (t1 < 0) begin
          t1 = k;
          o1 = bus4.out_state;
        end else begin
          t2 = k;
          o2 = bus4.out_state;
          break;
        end
      end
    end
    @(negedge clk);
    bus4.in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("b2b_first_out", o1, 128'h0);
    check("b2b_second_out", o2, {16{8'h52}});
    check("b2b_first_latency", t1, 5);
    check("b2b_spacing", t2 - t1, 7);
    check("b2b_idle_after", bus4.busy, 1'b0);

    // Reset during FEED beat 2
    @(negedge clk);
    bus4.in_valid = 1'b1;
    bus4.in_state = vecs[0].din;
    @(posedge clk);
    @(negedge clk);
    bus4.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_in_ready", bus4.in_ready, 1'b1);
    check("mid_rst_out_valid", bus4.out_valid, 1'b0);
    check("mid_rst_out_state", bus4.out_state, 128'h0);
    check("mid_rst_busy", bus4.busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    run_block(vecs[0].din, got, lat);
    check("post_rst_out", got, vecs[0].dout);
    check("post_rst_latency", lat, 5);

    // Parameter sweep: LANES=1 and LANES=16 on the basic vector
    @(negedge clk);
    bus1.in_valid  = 1'b1;
    bus1.in_state  = vecs[0].din;
    bus16.in_valid = 1'b1;
    bus16.in_state = vecs[0].din;
    @(posedge clk);
    @(negedge clk);
    bus1.in_valid  = 1'b0;
    bus16.in_valid = 1'b0;
    lat1  = -1;
    lat16 = -1;
    o16   = 'x;
    got   = 'x;
    for (int k = 1; k <= BOUND; k++) begin
      @(posedge clk);
      #1;
      if (bus1.out_valid && lat1 < 0) begin
        lat1 = k;
        got  = bus1.out_state;
      end
      if (bus16.out_valid && lat16 < 0) begin
        lat16 = k;
        o16   = bus16.out_state;
      end
      if (lat1 >= 0 && lat16 >= 0) break;
    end
    check("lanes1_out", got, vecs[0].dout);
    check("lanes1_latency", lat1, 17);
    check("lanes16_out", o16, vecs[0].dout);
    check("lanes16_latency", lat16, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
